// File: rtl/booth_digit_decoder.sv
// Serial radix-4 Booth digit decoder: rebuilds a signed value from {sign, mag2, mag1} digit
// slices, MSB digit first. Define BOOTH_DEC_CHECK_EN to report illegal digit codes on code_err.
module booth_digit_decoder #(
   parameter int unsigned N_DIGITS = 8,
   parameter int unsigned DATA_W   = 2 * N_DIGITS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_DIGITS-1:0] enc2,
   input  logic [N_DIGITS-1:0] enc1,
   input  logic [N_DIGITS-1:0] enc0,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data,
   output logic              code_err
);

   localparam int unsigned ACC_W = DATA_W + 2;
   localparam int unsigned CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state;
   logic [N_DIGITS-1:0]      e2_q;
   logic [N_DIGITS-1:0]      e1_q;
   logic [N_DIGITS-1:0]      e0_q;
   logic [CNT_W-1:0]         cnt;
   logic signed [ACC_W-1:0]  acc;

   logic                     dig_sign;
   logic                     dig_mag2;
   logic                     dig_mag1;
   logic signed [2:0]        dig_mag;
   logic signed [2:0]        dig_val;
   logic signed [ACC_W-1:0]  acc_nxt;

   // Current digit value; illegal codes fall out of the same mag2-over-mag1 priority
   always_comb begin
      dig_sign = e2_q[cnt];
      dig_mag2 = e1_q[cnt];
      dig_mag1 = e0_q[cnt];
      dig_mag  = dig_mag2 ? 3'sd2 : (dig_mag1 ? 3'sd1 : 3'sd0);
      dig_val  = dig_sign ? -dig_mag : dig_mag;
      acc_nxt  = (acc <<< 2) + ACC_W'(dig_val);
   end

`ifdef BOOTH_DEC_CHECK_EN
   logic err;
   logic dig_illegal;

   // 011 and 111 set both magnitude flags; 100 is a sign with no magnitude
   always_comb begin
      dig_illegal = (dig_mag2 & dig_mag1) | (dig_sign & ~dig_mag2 & ~dig_mag1);
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         data      <= '0;
         e2_q      <= '0;
         e1_q      <= '0;
         e0_q      <= '0;
         cnt       <= '0;
         acc       <= '0;
`ifdef BOOTH_DEC_CHECK_EN
         err       <= 1'b0;
         code_err  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  e2_q     <= enc2;
                  e1_q     <= enc1;
                  e0_q     <= enc0;
                  acc      <= '0;
                  cnt      <= CNT_W'(N_DIGITS - 1);
                  in_ready <= 1'b0;
                  state    <= RUN;
`ifdef BOOTH_DEC_CHECK_EN
                  err      <= 1'b0;
`endif
               end
            end
            RUN: begin
               acc <= acc_nxt;
               cnt <= cnt - CNT_W'(1);
`ifdef BOOTH_DEC_CHECK_EN
               err <= err | dig_illegal;
`endif
               if (cnt == '0) begin
                  data      <= acc_nxt[DATA_W-1:0];
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef BOOTH_DEC_CHECK_EN
                  code_err  <= err | dig_illegal;
`endif
               end
            end
            DONE: begin
               // in_ready rises only on the edge that retires the result, never alongside out_valid
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifndef BOOTH_DEC_CHECK_EN
   assign code_err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_digit_decoder.sv
// Directed-vector bench for booth_digit_decoder (default 8 digits, 16-bit result).
module tb_booth_digit_decoder;

   localparam int unsigned N_DIGITS = 8;
   localparam int unsigned DATA_W   = 16;
`ifdef BOOTH_DEC_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [N_DIGITS-1:0] enc2;
   logic [N_DIGITS-1:0] enc1;
   logic [N_DIGITS-1:0] enc0;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] data;
   logic              code_err;

   int total = 0;
   int bad   = 0;

   booth_digit_decoder #(.N_DIGITS(N_DIGITS), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .enc2      (enc2),
      .enc1      (enc1),
      .enc0      (enc0),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data      (data),
      .code_err  (code_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_ready(input string name);
      int cyc;
      cyc = 0;
      while (in_ready !== 1'b1 && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (in_ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL %s ready_timeout in_ready=%b required=1", name, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      enc2 = 8'hFF; enc1 = 8'hFF; enc0 = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++;
      if (data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h want=0000", data); end
      total++;
      if (code_err !== 1'b0) begin bad++; $display("FAIL reset_code_err got=%b want=0", code_err); end
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_set(input string name, input logic [7:0] e2, input logic [7:0] e1,
                                  input logic [7:0] e0, input logic [15:0] exp_d, input logic exp_e);
      int cyc;
      wait_ready(name);
      enc2 = e2; enc1 = e1; enc0 = e0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL %s busy_in_ready got=%b want=0", name, in_ready); end
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
      end
      total++;
      if (cyc != N_DIGITS) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, cyc, N_DIGITS); end
      total++;
      if (data !== exp_d) begin bad++; $display("FAIL %s data got=%h want=%h", name, data, exp_d); end
      total++;
      if (code_err !== exp_e) begin bad++; $display("FAIL %s code_err got=%b want=%b", name, code_err, exp_e); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s retire out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_values();
      test_single_set("zero",    8'h00, 8'h00, 8'h00, 16'h0000, 1'b0);
      test_single_set("min_neg", 8'h80, 8'h80, 8'h00, 16'h8000, 1'b0);
      test_single_set("max_pos", 8'h01, 8'h80, 8'h01, 16'h7FFF, 1'b0);
      test_single_set("minus1",  8'h01, 8'h00, 8'h01, 16'hFFFF, 1'b0);
      // digits 0,+1,0,+2,+1,-1,+1,0 -> 4096+512+64-16+4
      test_single_set("mixed",   8'h04, 8'h10, 8'h4E, 16'h1234, 1'b0);
   endtask

   task automatic test_illegal();
      test_single_set("code_100", 8'h01, 8'h00, 8'h00, 16'h0000, CHK);
      test_single_set("code_111", 8'h01, 8'h01, 8'h01, 16'hFFFE, CHK);
   endtask

   task automatic test_backpressure();
      int cyc;
      wait_ready("bp");
      enc2 = 8'h00; enc1 = 8'h08; enc0 = 8'h08; in_valid = 1'b1;
      @(posedge clk); #1;
      // new sets offered during RUN must not be captured; out_ready in RUN does nothing
      enc2 = 8'hFF; enc1 = 8'hFF; enc0 = 8'h00;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 30) begin
         out_ready = (cyc == 2);
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      total++;
      if (cyc != N_DIGITS) begin bad++; $display("FAIL bp latency got=%0d want=%0d", cyc, N_DIGITS); end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || data !== 16'h0080 || code_err !== CHK) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d out_valid=%b in_ready=%b data=%h code_err=%b want 1/0/0080/%b",
                     i, out_valid, in_ready, data, code_err, CHK);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_retire out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_no_capture in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      int overlap;
      logic [15:0] first_d;
      overlap = 0;
      wait_ready("b2b");
      out_ready = 1'b1;
      enc2 = 8'h01; enc1 = 8'h00; enc0 = 8'h01; in_valid = 1'b1;
      @(posedge clk); #1;
      enc2 = 8'h04; enc1 = 8'h10; enc0 = 8'h4E;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
      end
      first_d = data;
      total++;
      if (first_d !== 16'hFFFF) begin bad++; $display("FAIL b2b_first data got=%h want=ffff", first_d); end
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (in_ready === 1'b1 && out_valid === 1'b1) overlap++;
      end while (out_valid !== 1'b1 && cyc < 30);
      in_valid = 1'b0;
      total++;
      if (cyc != N_DIGITS + 2) begin bad++; $display("FAIL b2b_interval got=%0d want=%0d", cyc, N_DIGITS + 2); end
      total++;
      if (data !== 16'h1234) begin bad++; $display("FAIL b2b_second data got=%h want=1234", data); end
      total++;
      if (overlap != 0) begin bad++; $display("FAIL b2b_ready_overlap got=%0d want=0", overlap); end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      wait_ready("rst_mid");
      enc2 = 8'h01; enc1 = 8'h80; enc0 = 8'h01; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || data !== 16'h0000 || code_err !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid state in_ready=%b out_valid=%b data=%h code_err=%b want 1/0/0000/0",
                  in_ready, out_valid, data, code_err);
      end
      repeat (10) begin @(posedge clk); #1; end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_abandon out_valid=%b want=0", out_valid); end
      test_single_set("after_rst", 8'h00, 8'h00, 8'h01, 16'h0001, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      enc2 = '0; enc1 = '0; enc0 = '0;
      test_reset();
      test_values();
      test_illegal();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
